// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: operand forwarding selects, data/mult-div stall generation and HI/LO busy
// tracking, driven from decoded D-stage fields and private copies of the E/M/W records.
module hazard_scoreboard #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TNEW_W      = 3,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [TNEW_W-1:0] D_Tuse_rs,
  input  logic [TNEW_W-1:0] D_Tuse_rt,
  input  logic [REG_AW-1:0] D_A,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic [1:0]        D_md_op,
  input  logic              D_md_use,
  output logic              stall,
  output logic              md_busy,
  output logic [1:0]        D_fwd_rs,
  output logic [1:0]        D_fwd_rt,
  output logic [1:0]        E_fwd_rs,
  output logic [1:0]        E_fwd_rt,
  output logic [1:0]        M_fwd_rt
);

  localparam logic [1:0] MdMult = 2'd1;
  localparam logic [1:0] MdDiv  = 2'd2;

  // E keeps the full record; M only needs rt (store data) and W only its destination.
  logic [REG_AW-1:0] e_rs_q, e_rt_q, e_a_q, m_rt_q, m_a_q, w_a_q;
  logic [TNEW_W-1:0] e_tnew_q, m_tnew_q, w_tnew_q;
  logic [1:0]        e_md_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  function automatic logic hit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] a);
    return (r != '0) && (a == r);
  endfunction

  // Youngest match decides; a match still producing (Tnew>0) blocks older stages.
  function automatic logic [1:0] pick(
    input logic [REG_AW-1:0] r,
    input logic              use_e,
    input logic              use_m,
    input logic [REG_AW-1:0] ea, input logic [TNEW_W-1:0] et,
    input logic [REG_AW-1:0] ma, input logic [TNEW_W-1:0] mt,
    input logic [REG_AW-1:0] wa, input logic [TNEW_W-1:0] wt
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_e && hit(r, ea)) begin
      sel = (et == '0) ? 2'd1 : 2'd0;
    end else if (use_m && hit(r, ma)) begin
      sel = (mt == '0) ? 2'd2 : 2'd0;
    end else if (hit(r, wa)) begin
      sel = (wt == '0) ? 2'd3 : 2'd0;
    end
    return sel;
  endfunction

  function automatic logic data_stall(
    input logic [REG_AW-1:0] r,
    input logic [TNEW_W-1:0] tuse,
    input logic [REG_AW-1:0] ea, input logic [TNEW_W-1:0] et,
    input logic [REG_AW-1:0] ma, input logic [TNEW_W-1:0] mt
  );
    logic s;
    s = 1'b0;
    if (tuse != '1) begin
      if (hit(r, ea))      s = (et > tuse);
      else if (hit(r, ma)) s = (mt > tuse);
    end
    return s;
  endfunction

  logic md_stall;

  always_comb begin
    md_busy  = (cnt_q != '0);
    md_stall = D_md_use && (md_busy || e_md_q == MdMult || e_md_q == MdDiv);
    stall    = md_stall
            || data_stall(D_rs, D_Tuse_rs, e_a_q, e_tnew_q, m_a_q, m_tnew_q)
            || data_stall(D_rt, D_Tuse_rt, e_a_q, e_tnew_q, m_a_q, m_tnew_q);
    D_fwd_rs = pick(D_rs, 1'b1, 1'b1, e_a_q, e_tnew_q, m_a_q, m_tnew_q, w_a_q, w_tnew_q);
    D_fwd_rt = pick(D_rt, 1'b1, 1'b1, e_a_q, e_tnew_q, m_a_q, m_tnew_q, w_a_q, w_tnew_q);
    E_fwd_rs = pick(e_rs_q, 1'b0, 1'b1, e_a_q, e_tnew_q, m_a_q, m_tnew_q, w_a_q, w_tnew_q);
    E_fwd_rt = pick(e_rt_q, 1'b0, 1'b1, e_a_q, e_tnew_q, m_a_q, m_tnew_q, w_a_q, w_tnew_q);
    M_fwd_rt = pick(m_rt_q, 1'b0, 1'b0, e_a_q, e_tnew_q, m_a_q, m_tnew_q, w_a_q, w_tnew_q);
  end

  // Load wins over decrement; the busy window starts as the op leaves E.
  always_comb begin
    cnt_d = cnt_q;
    if (e_md_q == MdMult)    cnt_d = CNT_W'(MULT_CYCLES);
    else if (e_md_q == MdDiv) cnt_d = CNT_W'(DIV_CYCLES);
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_a_q    <= '0;
      e_tnew_q <= '0;
      e_md_q   <= '0;
      m_rt_q   <= '0;
      m_a_q    <= '0;
      m_tnew_q <= '0;
      w_a_q    <= '0;
      w_tnew_q <= '0;
      cnt_q    <= '0;
    end else begin
      w_a_q    <= m_a_q;
      w_tnew_q <= sat_dec(m_tnew_q);
      m_rt_q   <= e_rt_q;
      m_a_q    <= e_a_q;
      m_tnew_q <= sat_dec(e_tnew_q);
      cnt_q    <= cnt_d;
      if (stall) begin
        e_rs_q   <= '0;
        e_rt_q   <= '0;
        e_a_q    <= '0;
        e_tnew_q <= '0;
        e_md_q   <= '0;
      end else begin
        e_rs_q   <= D_rs;
        e_rt_q   <= D_rt;
        e_a_q    <= D_A;
        e_tnew_q <= D_Tnew;
        e_md_q   <= D_md_op;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios with literal expectations
// plus randomized traffic compared every cycle against an array-based pipeline model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A;
  logic [2:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic [1:0] D_md_op;
  logic       D_md_use;
  logic       stall, md_busy;
  logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .D_Tuse_rs(D_Tuse_rs),
    .D_Tuse_rt(D_Tuse_rt),
    .D_A      (D_A),
    .D_Tnew   (D_Tnew),
    .D_md_op  (D_md_op),
    .D_md_use (D_md_use),
    .stall    (stall),
    .md_busy  (md_busy),
    .D_fwd_rs (D_fwd_rs),
    .D_fwd_rt (D_fwd_rt),
    .E_fwd_rs (E_fwd_rs),
    .E_fwd_rt (E_fwd_rt),
    .M_fwd_rt (M_fwd_rt)
  );

  always #5 clk = ~clk;

  // Model: index 0 = E, 1 = M, 2 = W. Each slot is an in-flight instruction.
  int mrs[3], mrt[3], ma[3], mt[3], mmd[3];
  int mcnt;

  function automatic int youngest(int r, int first, int last);
    for (int i = first; i <= last; i++) if (r != 0 && ma[i] == r) return i;
    return -1;
  endfunction

  // Returns 1/2/3 for E/M/W, 0 if no match or the youngest match is not ready.
  function automatic int fsel(int r, int first, int last);
    int i;
    i = youngest(r, first, last);
    if (i >= 0 && mt[i] == 0) return i + 1;
    return 0;
  endfunction

  function automatic int dstall(int r, int tuse);
    int i;
    if (tuse == 7) return 0;
    i = youngest(r, 0, 1);
    return (i >= 0 && mt[i] > tuse) ? 1 : 0;
  endfunction

  function automatic int m_stall();
    int md;
    md = (D_md_use && (mcnt != 0 || mmd[0] == 1 || mmd[0] == 2)) ? 1 : 0;
    return (md != 0 || dstall(int'(D_rs), int'(D_Tuse_rs)) != 0
            || dstall(int'(D_rt), int'(D_Tuse_rt)) != 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("stall", 32'(stall), m_stall());
    chk("md_busy", 32'(md_busy), (mcnt != 0) ? 1 : 0);
    chk("D_fwd_rs", 32'(D_fwd_rs), fsel(int'(D_rs), 0, 2));
    chk("D_fwd_rt", 32'(D_fwd_rt), fsel(int'(D_rt), 0, 2));
    chk("E_fwd_rs", 32'(E_fwd_rs), fsel(mrs[0], 1, 2));
    chk("E_fwd_rt", 32'(E_fwd_rt), fsel(mrt[0], 1, 2));
    chk("M_fwd_rt", 32'(M_fwd_rt), fsel(mrt[1], 2, 2));
  endtask

  task automatic model_advance(input int s);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        mrs[i] = 0; mrt[i] = 0; ma[i] = 0; mt[i] = 0; mmd[i] = 0;
      end
      mcnt = 0;
    end else begin
      if (mmd[0] == 1)      mcnt = 5;
      else if (mmd[0] == 2) mcnt = 10;
      else if (mcnt > 0)    mcnt = mcnt - 1;
      for (int i = 2; i >= 1; i--) begin
        mrs[i] = mrs[i-1]; mrt[i] = mrt[i-1]; ma[i] = ma[i-1]; mmd[i] = mmd[i-1];
        mt[i]  = (mt[i-1] > 0) ? mt[i-1] - 1 : 0;
      end
      if (s != 0) begin
        mrs[0] = 0; mrt[0] = 0; ma[0] = 0; mt[0] = 0; mmd[0] = 0;
      end else begin
        mrs[0] = int'(D_rs); mrt[0] = int'(D_rt); ma[0] = int'(D_A);
        mt[0]  = int'(D_Tnew); mmd[0] = int'(D_md_op);
      end
    end
  endtask

  // Inputs are stable from edge+1; compare at edge+2, then update the model at the edge.
  task automatic cycle();
    int s;
    #1;
    model_check();
    s = m_stall();
    @(posedge clk);
    model_advance(s);
    #1;
  endtask

  task automatic nop();
    D_rs = 0; D_rt = 0; D_A = 0; D_Tnew = 0; D_md_op = 0; D_md_use = 0;
    D_Tuse_rs = 3'd7; D_Tuse_rt = 3'd7;
  endtask

  task automatic issue(input int a, input int tnew, input int md, input int use_md);
    nop();
    D_A = 5'(a); D_Tnew = 3'(tnew); D_md_op = 2'(md); D_md_use = (use_md != 0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      cycle();
    end
  endtask

  // Holds a HI/LO reader in D and measures how long it is held back.
  task automatic md_window(input int op, input int exp_stall, input int exp_busy,
                           input string tag);
    int stalls, busy;
    bit done;
    stalls = 0; busy = 0; done = 0;
    issue(0, 0, op, 1);
    cycle();
    nop();
    D_md_use = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall) begin
        stalls++;
        if (md_busy) busy++;
        cycle();
      end else begin
        done = 1;
      end
    end
    chk({tag, "_terminated"}, 32'(done), 1);
    chk({tag, "_stall_cycles"}, 32'(stalls), exp_stall);
    chk({tag, "_busy_cycles"}, 32'(busy), exp_busy);
    cycle();
    nops(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      mrs[i] = 0; mrt[i] = 0; ma[i] = 0; mt[i] = 0; mmd[i] = 0;
    end
    mcnt = 0;
    reset = 1;
    nop();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_fwd_all", {22'd0, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt}, 0);
    cycle();

    // Load -> use: producer ready only once it reaches W.
    issue(8, 2, 0, 0);
    cycle();
    nop(); D_rs = 8; D_Tuse_rs = 0;
    #1 chk("lu_stall_1", 32'(stall), 1);
    cycle();
    #1 chk("lu_stall_2", 32'(stall), 1);
    cycle();
    #1 chk("lu_stall_3", 32'(stall), 0);
    chk("lu_fwd_rs", 32'(D_fwd_rs), 3);
    cycle();
    nops(3);

    // ALU -> branch.
    issue(9, 1, 0, 0);
    cycle();
    nop(); D_rt = 9; D_Tuse_rt = 0;
    #1 chk("ab_stall_1", 32'(stall), 1);
    cycle();
    #1 chk("ab_stall_2", 32'(stall), 0);
    chk("ab_fwd_rt", 32'(D_fwd_rt), 2);
    cycle();
    nops(3);

    // ALU -> consumer needing rt one cycle later: no stall, forwarded in E.
    issue(9, 1, 0, 0);
    cycle();
    nop(); D_rt = 9; D_Tuse_rt = 1;
    #1 chk("al_stall", 32'(stall), 0);
    cycle();
    nop();
    #1 chk("al_E_fwd_rt", 32'(E_fwd_rt), 2);
    cycle();
    nops(3);

    // Blocking: younger not-ready E match hides the W copy.
    issue(7, 0, 0, 0);
    cycle();
    nop();
    cycle();
    issue(7, 1, 0, 0);
    cycle();
    nop(); D_rs = 7; D_Tuse_rs = 2;
    #1 chk("blk_stall", 32'(stall), 0);
    chk("blk_fwd_rs", 32'(D_fwd_rs), 0);
    cycle();
    nops(3);

    // Priority between M and W, and $0 never forwarded.
    issue(5, 0, 0, 0);
    cycle();
    issue(5, 0, 0, 0);
    cycle();
    nop();
    cycle();
    D_rs = 5; D_Tuse_rs = 0;
    #1 chk("pri_fwd_rs", 32'(D_fwd_rs), 2);
    chk("pri_stall", 32'(stall), 0);
    D_rs = 0;
    #1 chk("zero_fwd_rs", 32'(D_fwd_rs), 0);
    chk("zero_stall", 32'(stall), 0);
    cycle();
    nops(3);

    md_window(1, 6, 5, "mult");
    md_window(2, 11, 10, "div");

    // Reset in the middle of a divide, counter at 6.
    issue(0, 0, 2, 1);
    cycle();
    nop();
    for (int i = 0; i < 5; i++) cycle();
    D_md_use = 1;
    #1 chk("mid_div_busy", 32'(md_busy), 1);
    chk("mid_div_stall", 32'(stall), 1);
    reset = 1;
    cycle();
    reset = 0;
    #1 chk("post_rst_busy", 32'(md_busy), 0);
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_fwd", {22'd0, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt}, 0);
    cycle();

    // Random traffic on a small register set to provoke frequent hazards.
    for (int n = 0; n < 600; n++) begin
      int op, tu;
      reset = ($urandom_range(0, 99) == 0);
      D_rs   = 5'($urandom_range(0, 7));
      D_rt   = 5'($urandom_range(0, 7));
      D_A    = 5'($urandom_range(0, 7));
      D_Tnew = 3'($urandom_range(0, 2));
      tu = $urandom_range(0, 4);
      D_Tuse_rs = (tu == 4) ? 3'd7 : 3'(tu);
      tu = $urandom_range(0, 4);
      D_Tuse_rt = (tu == 4) ? 3'd7 : 3'(tu);
      op = $urandom_range(0, 15);
      D_md_op  = (op < 3) ? 2'(op + 1) : 2'd0;
      D_md_use = (op < 3) || ($urandom_range(0, 3) == 0);
      cycle();
    end
    reset = 0;
    nop();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
